// File: rtl/stream_align_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_align_if
// Brief    : Tag/data stream bundle and status outputs for stream_align.
// Revision : 1.0 - initial release
// ============================================================================
interface stream_align_if #(
    parameter int TAG_W  = 24,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 4
);
    logic              resync;
    logic              tag_valid;
    logic [TAG_W-1:0]  tag_in;
    logic              data_valid;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic [TAG_W-1:0]  out_tag;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   level;
    logic              overflow;
    logic              underflow;
    logic              locked;
    logic [7:0]        lat_meas;

    // Source side: drives the two streams, observes the aligned result.
    modport master (
        output resync, tag_valid, tag_in, data_valid, data_in,
        input  out_valid, out_tag, out_data, level, overflow, underflow,
               locked, lat_meas
    );

    modport slave (
        input  resync, tag_valid, tag_in, data_valid, data_in,
        output out_valid, out_tag, out_data, level, overflow, underflow,
               locked, lat_meas
    );
endinterface
`default_nettype wire

// File: rtl/stream_align.sv
`default_nettype none
// ============================================================================
// Module   : stream_align
// Brief    : Re-joins a tag stream with a fixed-latency data stream through a
//            tag FIFO and measures the tag-to-data latency.
// Revision : 1.0 - initial release
// ============================================================================
module stream_align #(
    parameter int TAG_W  = 24,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    stream_align_if.slave  sa
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_MEASURE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    localparam logic [ADDR_W:0] C_FULL    = (ADDR_W+1)'(DEPTH);
    localparam logic [7:0]      C_LAT_MAX = 8'hFF;

    logic [TAG_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_state;
    logic [7:0]        r_lat_cnt;

    logic              r_out_valid;
    logic [TAG_W-1:0]  r_out_tag;
    logic [DATA_W-1:0] r_out_data;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_locked;
    logic [7:0]        r_lat_meas;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_starve;
    logic w_flush;

    // Pop is decided on the start-of-cycle count, so a full FIFO can still
    // accept a tag in the same cycle it hands one out.
    assign w_flush  = rst || sa.resync;
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == C_FULL);
    assign w_pop    = sa.data_valid && !w_empty;
    assign w_push   = sa.tag_valid && (!w_full || w_pop);
    assign w_drop   = sa.tag_valid && w_full && !w_pop;
    assign w_starve = sa.data_valid && w_empty;

    always_ff @(posedge clk) begin
        if (!w_flush && w_push) begin
            r_mem[r_wr_ptr] <= sa.tag_in;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_out_valid <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_out_tag  <= r_mem[r_rd_ptr];
                r_out_data <= sa.data_in;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_starve) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Latency counter starts at 1 on the first tag so that the value held on
    // the first pop equals the number of cycles between tag and data.
    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_state    <= S_IDLE;
            r_lat_cnt  <= '0;
            r_lat_meas <= '0;
            r_locked   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_state   <= S_MEASURE;
                        r_lat_cnt <= 8'd1;
                    end
                end
                S_MEASURE: begin
                    if (w_pop) begin
                        r_state    <= S_LOCKED;
                        r_lat_meas <= r_lat_cnt;
                        r_locked   <= 1'b1;
                    end else if (r_lat_cnt != C_LAT_MAX) begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                S_LOCKED: begin
                    r_state <= S_LOCKED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign sa.out_valid = r_out_valid;
    assign sa.out_tag   = r_out_tag;
    assign sa.out_data  = r_out_data;
    assign sa.level     = r_count;
    assign sa.overflow  = r_overflow;
    assign sa.underflow = r_underflow;
    assign sa.locked    = r_locked;
    assign sa.lat_meas  = r_lat_meas;

endmodule
`default_nettype wire
